// File: rtl/sprite_plotter.sv
// sprite_plotter: rectangle-sprite rasteriser feeding vga_adapter.
// On each start it snapshots every sprite channel, then erases last frame's
// rectangles with BG_COLOUR and draws the new ones, one pixel per clock.
// Ports:
//   CLOCK_50    system clock
//   reset       synchronous, active-high
//   start       frame request, honoured only when idle
//   spr_x/y     packed sprite origins, sprite i at [i*W +: W]
//   spr_w/h     packed sprite widths / heights
//   spr_colour  packed sprite colours
//   spr_en      sprite enables
//   x/y/colour  registered pixel bus
//   writeEn     plot strobe, high only on in-bounds pixel cycles
//   busy        high while a frame is in progress
//   done        one-cycle pulse at frame end
module sprite_plotter #(
  parameter int unsigned N_SPRITES = 2,
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7,
  parameter int unsigned C_W       = 3,
  parameter int unsigned S_W       = 4,
  parameter int unsigned X_MAX     = 160,
  parameter int unsigned Y_MAX     = 120,
  parameter int unsigned BG_COLOUR = 0
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_SPRITES*X_W-1:0] spr_x,
  input  logic [N_SPRITES*Y_W-1:0] spr_y,
  input  logic [N_SPRITES*S_W-1:0] spr_w,
  input  logic [N_SPRITES*S_W-1:0] spr_h,
  input  logic [N_SPRITES*C_W-1:0] spr_colour,
  input  logic [N_SPRITES-1:0]     spr_en,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [C_W-1:0]           colour,
  output logic                     writeEn,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IdxW    = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_SPRITES - 1);
  localparam logic [S_W-1:0]  SOne    = S_W'(1);
  localparam logic [X_W:0]    XLim    = (X_W + 1)'(X_MAX);
  localparam logic [Y_W:0]    YLim    = (Y_W + 1)'(Y_MAX);
  localparam logic [C_W-1:0]  BgCol   = C_W'(BG_COLOUR);

  typedef enum logic [2:0] {StIdle, StLoad, StErase, StDraw, StDone} state_e;

  state_e state_q, state_d;

  // Sprite snapshots: "new" is this frame, "old" is what is currently on screen.
  logic [X_W-1:0] new_x   [N_SPRITES];
  logic [Y_W-1:0] new_y   [N_SPRITES];
  logic [S_W-1:0] new_w   [N_SPRITES];
  logic [S_W-1:0] new_h   [N_SPRITES];
  logic [C_W-1:0] new_col [N_SPRITES];
  logic           new_en  [N_SPRITES];
  logic [X_W-1:0] old_x   [N_SPRITES];
  logic [Y_W-1:0] old_y   [N_SPRITES];
  logic [S_W-1:0] old_w   [N_SPRITES];
  logic [S_W-1:0] old_h   [N_SPRITES];
  logic           old_en  [N_SPRITES];

  logic [IdxW-1:0] idx_q, idx_d;
  logic [S_W-1:0]  cx_q, cx_d, cy_q, cy_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [C_W-1:0]  colour_q, colour_d;
  logic            we_q, we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic [S_W-1:0] cur_w, cur_h;
  logic [C_W-1:0] cur_col;
  logic           cur_en;
  logic           skip, last_px, row_end;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;

  // Snapshot handling: capture in LOAD, retire new->old in DONE.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < int'(N_SPRITES); i++) begin
        new_x[i]   <= '0;
        new_y[i]   <= '0;
        new_w[i]   <= '0;
        new_h[i]   <= '0;
        new_col[i] <= '0;
        new_en[i]  <= 1'b0;
        old_x[i]   <= '0;
        old_y[i]   <= '0;
        old_w[i]   <= '0;
        old_h[i]   <= '0;
        old_en[i]  <= 1'b0;
      end
    end else if (state_q == StLoad) begin
      for (int i = 0; i < int'(N_SPRITES); i++) begin
        new_x[i]   <= spr_x[i*X_W +: X_W];
        new_y[i]   <= spr_y[i*Y_W +: Y_W];
        new_w[i]   <= spr_w[i*S_W +: S_W];
        new_h[i]   <= spr_h[i*S_W +: S_W];
        new_col[i] <= spr_colour[i*C_W +: C_W];
        new_en[i]  <= spr_en[i];
      end
    end else if (state_q == StDone) begin
      for (int i = 0; i < int'(N_SPRITES); i++) begin
        old_x[i]  <= new_x[i];
        old_y[i]  <= new_y[i];
        old_w[i]  <= new_w[i];
        old_h[i]  <= new_h[i];
        old_en[i] <= new_en[i];
      end
    end
  end

  // Current sprite: old set with background colour while erasing, new set while drawing.
  always_comb begin
    if (state_q == StDraw) begin
      cur_x   = new_x[idx_q];
      cur_y   = new_y[idx_q];
      cur_w   = new_w[idx_q];
      cur_h   = new_h[idx_q];
      cur_en  = new_en[idx_q];
      cur_col = new_col[idx_q];
    end else begin
      cur_x   = old_x[idx_q];
      cur_y   = old_y[idx_q];
      cur_w   = old_w[idx_q];
      cur_h   = old_h[idx_q];
      cur_en  = old_en[idx_q];
      cur_col = BgCol;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    we_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    skip    = ~cur_en | (cur_w == '0) | (cur_h == '0);
    // One extra bit so off-screen pixels are detected rather than wrapped.
    sum_x   = (X_W + 1)'(cur_x) + (X_W + 1)'(cx_q);
    sum_y   = (Y_W + 1)'(cur_y) + (Y_W + 1)'(cy_q);
    row_end = (cx_q == cur_w - SOne);
    last_px = skip | (row_end & (cy_q == cur_h - SOne));

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        busy_d  = 1'b1;
        idx_d   = '0;
        cx_d    = '0;
        cy_d    = '0;
        state_d = StErase;
      end
      StErase, StDraw: begin
        busy_d   = 1'b1;
        x_d      = sum_x[X_W-1:0];
        y_d      = sum_y[Y_W-1:0];
        colour_d = cur_col;
        we_d     = ~skip & (sum_x < XLim) & (sum_y < YLim);
        if (last_px) begin
          cx_d = '0;
          cy_d = '0;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = (state_q == StErase) ? StDraw : StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (row_end) begin
          cx_d = '0;
          cy_d = cy_q + SOne;
        end else begin
          cx_d = cx_q + SOne;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign writeEn = we_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Bench for sprite_plotter (two sprite channels). A frame planner pushes every
// expected plotted pixel with its cycle into a queue when start is driven; a
// monitor pops and compares each pixel as writeEn appears. Scenario tasks
// check frame timing, write counts and reset behaviour inline.
`timescale 1ns/1ps
module tb_sprite_plotter;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [N*8-1:0] spr_x = '0;
  logic [N*7-1:0] spr_y = '0;
  logic [N*4-1:0] spr_w = '0;
  logic [N*4-1:0] spr_h = '0;
  logic [N*3-1:0] spr_colour = '0;
  logic [N-1:0]   spr_en = '0;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           writeEn, busy, done;

  sprite_plotter #(.N_SPRITES(N)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .start     (start),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .spr_w     (spr_w),
    .spr_h     (spr_h),
    .spr_colour(spr_colour),
    .spr_en    (spr_en),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .writeEn   (writeEn),
    .busy      (busy),
    .done      (done)
  );

  always #10 clk = ~clk;

  typedef struct {
    int cyc;
    int px;
    int py;
    int c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done = -1;
  int   wr_cnt = 0;
  int   exp_done = 0;

  // Sprites currently on screen according to the bench's own reckoning.
  int m_old_x [N];
  int m_old_y [N];
  int m_old_w [N];
  int m_old_h [N];
  int m_old_en[N];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (writeEn) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected cyc %0d got (%0d,%0d) c%0d, none expected",
                 cyc, x, y, colour);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || int'(x) !== mon_e.px || int'(y) !== mon_e.py ||
            int'(colour) !== mon_e.c) begin
          errors++;
          $display("FAIL write_check got cyc %0d (%0d,%0d) c%0d, expected cyc %0d (%0d,%0d) c%0d",
                   cyc, x, y, colour, mon_e.cyc, mon_e.px, mon_e.py, mon_e.c);
        end
      end
    end
    if (done) begin
      done_cnt++;
      last_done = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got cyc %0d, required finish earlier", cyc);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_old_x[i] = 0; m_old_y[i] = 0; m_old_w[i] = 0; m_old_h[i] = 0; m_old_en[i] = 0;
    end
  endtask

  task automatic set_sprite(input int i, input int sx, input int sy, input int sw,
                            input int sh, input int sc, input bit en);
    spr_x[i*8 +: 8]      = 8'(sx);
    spr_y[i*7 +: 7]      = 7'(sy);
    spr_w[i*4 +: 4]      = 4'(sw);
    spr_h[i*4 +: 4]      = 4'(sh);
    spr_colour[i*3 +: 3] = 3'(sc);
    spr_en[i]            = en;
  endtask

  // Expected pixel stream for a frame whose start is sampled at edge t.
  task automatic plan(input int t);
    int c;
    c = t + 2;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < N; i++) begin
        int ox, oy, w, h, col, en;
        if (ph == 0) begin
          ox = m_old_x[i]; oy = m_old_y[i]; w = m_old_w[i]; h = m_old_h[i];
          en = m_old_en[i]; col = 0;
        end else begin
          ox = int'(spr_x[i*8 +: 8]); oy = int'(spr_y[i*7 +: 7]);
          w = int'(spr_w[i*4 +: 4]); h = int'(spr_h[i*4 +: 4]);
          en = int'(spr_en[i]); col = int'(spr_colour[i*3 +: 3]);
        end
        if (en == 0 || w == 0 || h == 0) begin
          c++;
        end else begin
          for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
              if (ox + xx < 160 && oy + yy < 120) exp_q.push_back('{c, ox + xx, oy + yy, col});
              c++;
            end
          end
        end
      end
    end
    exp_done = c;
    for (int i = 0; i < N; i++) begin
      m_old_x[i] = int'(spr_x[i*8 +: 8]); m_old_y[i] = int'(spr_y[i*7 +: 7]);
      m_old_w[i] = int'(spr_w[i*4 +: 4]); m_old_h[i] = int'(spr_h[i*4 +: 4]);
      m_old_en[i] = int'(spr_en[i]);
    end
  endtask

  // Leaves the bench sitting just after edge t.
  task automatic start_frame(output int t);
    start = 1'b1;
    t = cyc + 1;
    last_done = -1;
    plan(t);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < limit && done_cnt == d0; k++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
      errors++;
      $display("FAIL reset_pixel got (%0d,%0d) c%0d, required (0,0) c0", x, y, colour);
    end
    checks++;
    if (writeEn !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got we%0b busy%0b done%0b, required 000", writeEn, busy, done);
    end
    reset = 1'b0;
    exp_q.delete();
    clear_model();
    step();
  endtask

  task automatic test_first_frame();
    int t, w0;
    set_sprite(0, 10, 20, 2, 2, 3, 1'b1);
    set_sprite(1, 0, 0, 0, 0, 0, 1'b0);
    w0 = wr_cnt;
    start_frame(t);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL first_busy_t got %0b, required 0", busy);
    end
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL first_busy_t1 got %0b, required 1", busy);
    end
    wait_done(100);
    checks++;
    if (last_done - t !== 9) begin
      errors++;
      $display("FAIL first_done_offset got %0d, required 9", last_done - t);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL first_busy_done got %0b, required 0", busy);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL first_done_pulse got %0b, required 0", done);
    end
    checks++;
    if (wr_cnt - w0 !== 4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL first_writes got %0d left %0d, required 4 left 0", wr_cnt - w0, exp_q.size());
    end
  endtask

  task automatic test_move();
    int t, w0;
    set_sprite(0, 11, 20, 2, 2, 3, 1'b1);
    w0 = wr_cnt;
    start_frame(t);
    step();
    step();
    // Post-LOAD input changes must not leak into this frame.
    set_sprite(0, 90, 90, 5, 5, 1, 1'b1);
    wait_done(100);
    checks++;
    if (last_done - t !== 12) begin
      errors++;
      $display("FAIL move_done_offset got %0d, required 12", last_done - t);
    end
    checks++;
    if (wr_cnt - w0 !== 8 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL move_writes got %0d left %0d, required 8 left 0", wr_cnt - w0, exp_q.size());
    end
    step();
  endtask

  task automatic test_clip();
    int t, w0;
    set_sprite(0, 158, 119, 4, 2, 5, 1'b1);
    w0 = wr_cnt;
    start_frame(t);
    wait_done(100);
    checks++;
    if (last_done - t !== 16) begin
      errors++;
      $display("FAIL clip_done_offset got %0d, required 16", last_done - t);
    end
    checks++;
    if (wr_cnt - w0 !== 6 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL clip_writes got %0d left %0d, required 6 left 0", wr_cnt - w0, exp_q.size());
    end
    step();
  endtask

  task automatic test_skip();
    int t, w0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    clear_model();
    step();
    set_sprite(0, 60, 60, 3, 3, 4, 1'b0);
    set_sprite(1, 5, 5, 1, 1, 7, 1'b1);
    w0 = wr_cnt;
    start_frame(t);
    wait_done(100);
    checks++;
    if (last_done - t !== 6) begin
      errors++;
      $display("FAIL skip_done_offset got %0d, required 6", last_done - t);
    end
    checks++;
    if (wr_cnt - w0 !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL skip_writes got %0d left %0d, required 1 left 0", wr_cnt - w0, exp_q.size());
    end
    step();
  endtask

  task automatic test_busy();
    int t, d0, w0, busy_seen;
    set_sprite(0, 30, 40, 3, 3, 2, 1'b1);
    set_sprite(1, 0, 0, 0, 0, 0, 1'b0);
    d0 = done_cnt;
    w0 = wr_cnt;
    start_frame(t);
    while (cyc < t + 6) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100);
    checks++;
    if (last_done - t !== 14) begin
      errors++;
      $display("FAIL busy_done_offset got %0d, required 14", last_done - t);
    end
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (busy) busy_seen++;
    end
    checks++;
    if (done_cnt - d0 !== 1 || busy_seen !== 0) begin
      errors++;
      $display("FAIL busy_no_restart got dones %0d busy %0d, required 1 and 0",
               done_cnt - d0, busy_seen);
    end
    checks++;
    if (wr_cnt - w0 !== 10) begin
      errors++;
      $display("FAIL busy_writes got %0d, required 10", wr_cnt - w0);
    end
    w0 = wr_cnt;
    start_frame(t);
    wait_done(100);
    checks++;
    if (last_done - t !== 22 || wr_cnt - w0 !== 18) begin
      errors++;
      $display("FAIL busy_next_frame got offset %0d writes %0d, required 22 and 18",
               last_done - t, wr_cnt - w0);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int t, w0;
    set_sprite(0, 50, 50, 4, 4, 6, 1'b1);
    start_frame(t);
    while (cyc < t + 14) step();
    reset = 1'b1;
    step();
    checks++;
    if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
      errors++;
      $display("FAIL midreset_pixel got (%0d,%0d) c%0d, required (0,0) c0", x, y, colour);
    end
    checks++;
    if (writeEn !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl got we%0b busy%0b done%0b, required 000", writeEn, busy, done);
    end
    reset = 1'b0;
    exp_q.delete();
    clear_model();
    step();
    w0 = wr_cnt;
    start_frame(t);
    wait_done(100);
    checks++;
    if (last_done - t !== 21 || wr_cnt - w0 !== 16 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL midreset_next got offset %0d writes %0d left %0d, required 21 16 0",
               last_done - t, wr_cnt - w0, exp_q.size());
    end
    step();
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_move();
    test_clip();
    test_skip();
    test_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
